// File: rtl/thread_pc_sched.sv
// N-thread PC file and round-robin fetch scheduler for the barrel datapath.
// Define THREAD_SCHED_STRICT_RR_EN for fixed barrel slots instead of skipping.
module thread_pc_sched #(
  parameter int N_THREADS       = 4,
  parameter int PC_WIDTH        = 32,
  parameter int INSTR_BYTES     = 4,
  parameter int RESET_PC_BASE   = 0,
  parameter int RESET_PC_STRIDE = 4,
  localparam int TID_W = $clog2(N_THREADS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_en,
  input  logic [N_THREADS-1:0] thread_active,
  input  logic                 redirect_valid,
  input  logic [TID_W-1:0]     redirect_tid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 fetch_valid,
  output logic [TID_W-1:0]     fetch_tid,
  output logic [N_THREADS-1:0] fetch_thread,
  output logic [PC_WIDTH-1:0]  fetch_pc
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(STEP - 1'b1);
  localparam logic [TID_W:0] N_LIM = (TID_W+1)'(N_THREADS);
  localparam logic [TID_W-1:0] LAST_TID = TID_W'(N_THREADS - 1);

  logic [PC_WIDTH-1:0]  pc      [N_THREADS];
  logic [PC_WIDTH-1:0]  pc_view [N_THREADS];
  logic [N_THREADS-1:0] redir_hit;
  logic [PC_WIDTH-1:0]  redir_pc;
  logic [PC_WIDTH-1:0]  sel_pc;
  logic [TID_W-1:0]     last_tid;
  logic [TID_W-1:0]     sel;
  logic                 redir_ok;
  logic                 found;
  logic                 take;

  assign redir_ok = redirect_valid && ({1'b0, redirect_tid} < N_LIM);
  assign redir_pc = redirect_pc & ALIGN_MASK;

  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      redir_hit[i] = redir_ok && (redirect_tid == TID_W'(i));
      pc_view[i]   = redir_hit[i] ? redir_pc : pc[i];
    end
  end

`ifdef THREAD_SCHED_STRICT_RR_EN
  always_comb begin
    sel   = (last_tid == LAST_TID) ? '0 : last_tid + 1'b1;
    found = thread_active[sel];
    take  = 1'b1;
  end
`else
  // Rotating priority: last_tid itself is checked last.
  always_comb begin
    int j;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_THREADS; k++) begin
      j = int'(last_tid) + k;
      if (j >= N_THREADS) j = j - N_THREADS;
      if (!found && thread_active[j]) begin
        found = 1'b1;
        sel   = TID_W'(j);
      end
    end
    take = found;
  end
`endif

  assign sel_pc = pc_view[sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_THREADS; i++)
        pc[i] <= PC_WIDTH'(RESET_PC_BASE + i * RESET_PC_STRIDE);
      last_tid    <= LAST_TID;
      fetch_valid <= 1'b0;
      fetch_tid   <= '0;
      fetch_pc    <= '0;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (pc_en && found && sel == TID_W'(i))
          pc[i] <= pc_view[i] + STEP;
        else if (redir_hit[i])
          pc[i] <= pc_view[i];
      end
      if (pc_en) begin
        fetch_valid <= found;
        if (take) begin
          last_tid  <= sel;
          fetch_tid <= sel;
        end
        if (found) fetch_pc <= sel_pc;
      end
    end
  end

  always_comb begin
    fetch_thread = '0;
    if (fetch_valid) fetch_thread[fetch_tid] = 1'b1;
  end

endmodule

// File: tb/tb_thread_pc_sched.sv
// Directed bench for thread_pc_sched with N_THREADS=4 and default parameters.
// Expectations follow the strict-slot variant when THREAD_SCHED_STRICT_RR_EN is set.
module tb_thread_pc_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_en = 1'b0;
  logic [3:0]  thread_active = '0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_tid = '0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [1:0]  fetch_tid;
  logic [3:0]  fetch_thread;
  logic [31:0] fetch_pc;

  int total = 0;
  int bad = 0;

  thread_pc_sched dut (
    .clk(clk),
    .reset(reset),
    .pc_en(pc_en),
    .thread_active(thread_active),
    .redirect_valid(redirect_valid),
    .redirect_tid(redirect_tid),
    .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid),
    .fetch_tid(fetch_tid),
    .fetch_thread(fetch_thread),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pc_en = 1'b0;
    thread_active = '0;
    redirect_valid = 1'b0;
    redirect_tid = '0;
    redirect_pc = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc_en = 1'b1;
    thread_active = 4'b1111;
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_thread, fetch_pc} !== 39'd0) begin
      bad++;
      $display("FAIL reset: got v=%b t=%0d th=%b pc=%h want all zero",
               fetch_valid, fetch_tid, fetch_thread, fetch_pc);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [1:0]  et [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] ep [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h4, 32'h8};
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({fetch_valid, fetch_tid, fetch_thread, fetch_pc} !==
          {1'b1, et[i], 4'b0001 << et[i], ep[i]}) begin
        bad++;
        $display("FAIL rr[%0d]: got v=%b t=%0d th=%b pc=%h want t=%0d pc=%h",
                 i, fetch_valid, fetch_tid, fetch_thread, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_skip_inactive();
`ifdef THREAD_SCHED_STRICT_RR_EN
    logic        ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  et [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] ep [4] = '{32'h0, 32'h0, 32'h8, 32'h8};
`else
    logic        ev [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  et [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] ep [4] = '{32'h0, 32'h8, 32'h4, 32'hC};
`endif
    logic [3:0] eth;
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      eth = ev[i] ? (4'b0001 << et[i]) : 4'b0000;
      total++;
      if ({fetch_valid, fetch_tid, fetch_thread} !== {ev[i], et[i], eth} ||
          (ev[i] && fetch_pc !== ep[i])) begin
        bad++;
        $display("FAIL skip[%0d]: got v=%b t=%0d th=%b pc=%h want v=%b t=%0d th=%b pc=%h",
                 i, fetch_valid, fetch_tid, fetch_thread, fetch_pc,
                 ev[i], et[i], eth, ep[i]);
      end
    end
  endtask

  task automatic test_redirect_selected();
    logic [1:0]  et [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] ep [4] = '{32'hC, 32'h4, 32'h8, 32'h104};
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b1111;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_tid = 2'd2;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd2, 32'h100}) begin
      bad++;
      $display("FAIL redir_sel: got v=%b t=%0d pc=%h want t=2 pc=00000100",
               fetch_valid, fetch_tid, fetch_pc);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, et[i], ep[i]}) begin
        bad++;
        $display("FAIL redir_after[%0d]: got v=%b t=%0d pc=%h want t=%0d pc=%h",
                 i, fetch_valid, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b1111;
    step();
    pc_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_tid = 2'd1;
    redirect_pc = 32'h2003;
    for (int i = 0; i < 2; i++) begin
      step();
      redirect_valid = 1'b0;
      total++;
      if ({fetch_valid, fetch_tid, fetch_thread, fetch_pc} !==
          {1'b1, 2'd0, 4'b0001, 32'h0}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got v=%b t=%0d th=%b pc=%h want t=0 pc=0",
                 i, fetch_valid, fetch_tid, fetch_thread, fetch_pc);
      end
    end
    pc_en = 1'b1;
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd1, 32'h2000}) begin
      bad++;
      $display("FAIL stall_redir: got v=%b t=%0d pc=%h want t=1 pc=00002000",
               fetch_valid, fetch_tid, fetch_pc);
    end
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd2, 32'h8}) begin
      bad++;
      $display("FAIL stall_next: got v=%b t=%0d pc=%h want t=2 pc=00000008",
               fetch_valid, fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_idle_resume();
    logic [1:0]  et [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] ep [3] = '{32'h4, 32'h8, 32'h8};
    int n;
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b1111;
    step();
    step();
    thread_active = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({fetch_valid, fetch_thread} !== 5'b0) begin
        bad++;
        $display("FAIL idle[%0d]: got v=%b th=%b want v=0 th=0000",
                 i, fetch_valid, fetch_thread);
      end
    end
    thread_active = 4'b1000;
    n = 0;
    do begin
      step();
      n++;
    end while (!fetch_valid && n < 8);
    total++;
    if ({fetch_valid, fetch_tid, fetch_thread, fetch_pc} !==
        {1'b1, 2'd3, 4'b1000, 32'hC}) begin
      bad++;
      $display("FAIL resume_t3: got v=%b t=%0d th=%b pc=%h want t=3 pc=0000000c",
               fetch_valid, fetch_tid, fetch_thread, fetch_pc);
    end
    thread_active = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, et[i], ep[i]}) begin
        bad++;
        $display("FAIL resume[%0d]: got v=%b t=%0d pc=%h want t=%0d pc=%h",
                 i, fetch_valid, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    do_reset();
    pc_en = 1'b1;
    thread_active = 4'b0001;
    redirect_valid = 1'b1;
    redirect_tid = 2'd0;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'hFFFF_FFFC}) begin
      bad++;
      $display("FAIL wrap_top: got v=%b t=%0d pc=%h want t=0 pc=fffffffc",
               fetch_valid, fetch_tid, fetch_pc);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!fetch_valid && n < 8);
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h0}) begin
      bad++;
      $display("FAIL wrap_zero: got v=%b t=%0d pc=%h want t=0 pc=00000000",
               fetch_valid, fetch_tid, fetch_pc);
    end
    thread_active = 4'b1111;
    step();
    reset = 1'b1;
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_thread, fetch_pc} !== 39'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b t=%0d th=%b pc=%h want all zero",
               fetch_valid, fetch_tid, fetch_thread, fetch_pc);
    end
    reset = 1'b0;
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h0}) begin
      bad++;
      $display("FAIL post_reset0: got v=%b t=%0d pc=%h want t=0 pc=0",
               fetch_valid, fetch_tid, fetch_pc);
    end
    step();
    total++;
    if ({fetch_valid, fetch_tid, fetch_pc} !== {1'b1, 2'd1, 32'h4}) begin
      bad++;
      $display("FAIL post_reset1: got v=%b t=%0d pc=%h want t=1 pc=4",
               fetch_valid, fetch_tid, fetch_pc);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_inactive();
    test_redirect_selected();
    test_stall_redirect();
    test_idle_resume();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
